pc_sequencer: RTL
=================

# pc_sequencer

Program-counter sequencer for the strawberry core. Holds the PC and advances it every cycle by increment, branch, call or return. For delay instructions it runs a two-phase handshake with the downstream delay counter. It drives `delayEn` to the delay counter and consumes that block's `pcEn`, freezing the PC until the delay completes.

## Interface
- `ADDR_W`, 8, PC / instruction-address width.
- `STACK_DEPTH`, 4, return-stack entries (power of two, ≥2).
- `RESET_VEC`, 0, PC value after reset.
- `ARM_TIMEOUT`, 15, cycles to wait for `pcEn` to fall after `delayEn` rises.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstN`  in  1  reset, asynchronous assert, active-low.
- `pcEn`  in  1  run-enable from the delay counter; asynchronous to `clk`, so it is synchronized internally.
- `delayReq`  in  1  current instruction is a delay.
- `branchTaken`  in  1  take branch to `target`.
- `call`  in  1  push return address and jump to `target`.
- `ret`  in  1  pop the return address into the PC.
- `halt`  in  1  stop sequencing until reset.
- `target`  in  ADDR_W  branch/call destination.
- `pc`  out  ADDR_W  current fetch address.
- `delayEn`  out  1  delay-start level to the delay counter.
- `busy`  out  1  high while not in RUN.
- `stackErr`  out  1  sticky overflow/underflow flag.
- `armTimeout`  out  1  sticky: the delay counter never acknowledged.

## Operation
- `pcEn` passes through a 2-flop synchronizer, reset value 1, giving `pcEnS`.
- States are RUN, DLY_ARM, DLY_WAIT and HALTED.
- **RUN.** Per cycle, priority is halt > delayReq > ret > call > branchTaken > increment.
  - halt: PC holds; go to HALTED.
  - delayReq: PC holds; `delayEn`←1; clear arm counter; go to DLY_ARM.
  - ret: PC ← popped value. If the stack is empty, PC ← PC+1 and `stackErr`←1.
  - call: push PC+1, then PC ← `target`. If the stack is full, the push is dropped, `stackErr`←1, and the jump still happens.
  - branchTaken: PC ← `target`.
  - otherwise: PC ← PC+1.
- **DLY_ARM.** `delayEn` stays 1 and the arm counter increments.
  - `pcEnS`==0: `delayEn`←0; go to DLY_WAIT.
  - Counter reaches ARM_TIMEOUT first: `delayEn`←0, `armTimeout`←1, PC ← PC+1, go to RUN.
- **DLY_WAIT.** `delayEn`=0 and the PC holds. When `pcEnS`==1: PC ← PC+1; go to RUN.
- **HALTED.** All outputs hold. Only `rstN` exits this state.
- Control inputs are ignored outside RUN.
- Arithmetic is mod 2^ADDR_W: PC+1 from all-ones wraps to 0, and the pushed return address wraps the same way.
- When call and ret are both asserted, ret wins: the stack is popped and nothing is pushed.

## Timing
- On reset:
  - `pc`=RESET_VEC;
  - `delayEn`=0, `busy`=0, `stackErr`=0, `armTimeout`=0;
  - state RUN;
  - stack pointer 0.
- Reset asserted mid-delay drops `delayEn` immediately (asynchronous) and abandons the handshake.
- All outputs are registered. A control input sampled at edge N takes effect on `pc` after edge N.
- `delayEn` rises 1 cycle after `delayReq` is sampled.
- A `pcEn` edge is seen 2–3 cycles after it occurs. A delay therefore costs (delay length) + about 4–6 cycles.
- `delayEn` is a level held ≥1 cycle, giving the delay counter a clean rising edge. It is never re-asserted until the state has returned to RUN.
- A `pcEnS` low pulse arriving while in RUN is ignored.
- `busy`=1 exactly in DLY_ARM, DLY_WAIT and HALTED.

## Structure
- Package `strawberry_pkg` holds:
  - the state enum (RUN, DLY_ARM, DLY_WAIT, HALTED);
  - the default ADDR_W;
  - the sync-stage count constant (2).
- Sub-module `pc_return_stack`: a LIFO of STACK_DEPTH×ADDR_W.
  - Ports: push, pop, din, dout, full, empty.
  - Behaviour: registered pointer; pop-on-empty and push-on-full are no-ops.
- The sequencer keeps the FSM, the synchronizer, the arm counter and the PC register.

## Test plan
- Increment and wrap: after reset, run with no controls for 300 cycles at ADDR_W=8. Required: `pc` goes 0,1,…,255,0,1; `busy`=0 throughout.
- Branch, call, return: at pc=5 assert call with target=0x40; at pc=0x42 assert ret. Required: `pc` goes 0x40, then 0x41, 0x42, then 6; `stackErr`=0.
- Stack boundaries: five nested calls with STACK_DEPTH=4, then five rets. Required:
  - `stackErr`=1 after the fifth call;
  - the first four rets return the four stored addresses in LIFO order;
  - the fifth ret gives PC+1.
- Delay handshake: at pc=0x10 assert delayReq; the model drops `pcEn` 1 cycle after `delayEn` rises and raises it 50 cycles later. Required:
  - `delayEn` high for 3–4 cycles;
  - `pc` holds at 0x10 until 2–3 cycles after `pcEn` rises, then becomes 0x11;
  - `busy` low again.
- Timeout and reset mid-delay:
  - The model never drops `pcEn`. Required: after 15 cycles in DLY_ARM, `armTimeout`=1 and pc advances by 1.
  - Repeat, then pulse `rstN` low in DLY_WAIT. Required: `delayEn`=0 and `pc`=RESET_VEC immediately.

Source files
------------

// File: rtl/strawberry_pkg.sv
// Shared types and constants for the strawberry core's PC sequencing logic.
package strawberry_pkg;

  // Sequencer FSM states; encoding is also visible on the debug state output.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DLY_ARM  = 2'd1,
    DLY_WAIT = 2'd2,
    HALTED   = 2'd3
  } seqState_t;

  // Default instruction-address width for the core.
  localparam int DEFAULT_ADDR_W = 8;

  // Number of flops used to bring the delay counter's pcEn into the clk domain.
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO for call/ret. The pointer counts occupied entries, so
// full/empty fall straight out of it; pop-on-empty and push-on-full do nothing.
module pc_return_stack
  import strawberry_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]  sp;
  logic [PTR_W-1:0]  spDec;
  logic [IDX_W-1:0]  topIdx;

  assign full   = (sp == PTR_W'(STACK_DEPTH));
  assign empty  = (sp == '0);
  assign spDec  = sp - PTR_W'(1);
  assign topIdx = spDec[IDX_W-1:0];
  // Top of stack is always presented; it is only meaningful when not empty.
  assign dout   = mem[topIdx];

  // Pointer and storage update; a pop takes precedence if both are requested.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sp <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (pop) begin
      if (!empty) begin
        sp <= spDec;
      end
    end else if (push) begin
      if (!full) begin
        mem[sp[IDX_W-1:0]] <= din;
        sp                 <= sp + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: advances the PC by increment, branch, call or
// return, and runs a two-phase delayEn/pcEn handshake with the delay counter
// that freezes the PC until the delay completes.
//
// Handshake: delayEn is a level raised when a delay instruction is accepted
// and held until the synchronized pcEn is seen low (the counter has started)
// or the arm timeout expires. The PC then stays frozen until the synchronized
// pcEn returns high. delayEn is never raised again before the FSM is back in
// RUN, so the counter always sees a clean rising edge.
module pc_sequencer
  import strawberry_pkg::*;
#(
  parameter int                ADDR_W      = DEFAULT_ADDR_W,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                ARM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              pcEn,
  input  logic              delayReq,
  input  logic              branchTaken,
  input  logic              call,
  input  logic              ret,
  input  logic              halt,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic              delayEn,
  output logic              busy,
  output logic              stackErr,
  output logic              armTimeout,
  output seqState_t         dbgState
);

  localparam int CNT_W = $clog2(ARM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_TIMEOUT - 1);

  seqState_t         state, stateNext;
  logic [ADDR_W-1:0] pcNext;
  logic [ADDR_W-1:0] pcInc;
  logic              delayEnNext;
  logic              busyNext;
  logic              stackErrNext;
  logic              armTimeoutNext;
  logic [CNT_W-1:0]  armCnt, armCntNext;

  logic [SYNC_STAGES-1:0] pcEnSync;
  logic                   pcEnS;

  logic              stkPush;
  logic              stkPop;
  logic [ADDR_W-1:0] stkTop;
  logic              stkFull;
  logic              stkEmpty;

  // Increment wraps naturally at 2^ADDR_W; also used as the return address.
  assign pcInc    = pc + ADDR_W'(1);
  assign pcEnS    = pcEnSync[SYNC_STAGES-1];
  assign dbgState = state;

  pc_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) uStack (
    .clk   (clk),
    .rstN  (rstN),
    .push  (stkPush),
    .pop   (stkPop),
    .din   (pcInc),
    .dout  (stkTop),
    .full  (stkFull),
    .empty (stkEmpty)
  );

  // Bring the asynchronous pcEn into the clk domain; idle level is high.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pcEnSync <= '1;
    end else begin
      pcEnSync <= {pcEnSync[SYNC_STAGES-2:0], pcEn};
    end
  end

  // State and registered outputs; reset drops delayEn at once, abandoning any handshake.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= RUN;
      pc         <= RESET_VEC;
      delayEn    <= 1'b0;
      busy       <= 1'b0;
      stackErr   <= 1'b0;
      armTimeout <= 1'b0;
      armCnt     <= '0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      delayEn    <= delayEnNext;
      busy       <= busyNext;
      stackErr   <= stackErrNext;
      armTimeout <= armTimeoutNext;
      armCnt     <= armCntNext;
    end
  end

  // Next-state, next-PC and stack control; everything holds unless a branch below changes it.
  always_comb begin
    stateNext      = state;
    pcNext         = pc;
    delayEnNext    = delayEn;
    stackErrNext   = stackErr;
    armTimeoutNext = armTimeout;
    armCntNext     = armCnt;
    stkPush        = 1'b0;
    stkPop         = 1'b0;

    unique case (state)
      RUN: begin
        // Priority: halt > delayReq > ret > call > branchTaken > increment.
        if (halt) begin
          stateNext = HALTED;
        end else if (delayReq) begin
          delayEnNext = 1'b1;
          armCntNext  = '0;
          stateNext   = DLY_ARM;
        end else if (ret) begin
          // ret wins over a simultaneous call, so nothing is pushed here.
          if (stkEmpty) begin
            pcNext       = pcInc;
            stackErrNext = 1'b1;
          end else begin
            stkPop = 1'b1;
            pcNext = stkTop;
          end
        end else if (call) begin
          // On a full stack the push is dropped but the jump still happens.
          stkPush = 1'b1;
          pcNext  = target;
          if (stkFull) begin
            stackErrNext = 1'b1;
          end
        end else if (branchTaken) begin
          pcNext = target;
        end else begin
          pcNext = pcInc;
        end
      end

      DLY_ARM: begin
        if (!pcEnS) begin
          delayEnNext = 1'b0;
          stateNext   = DLY_WAIT;
        end else if (armCnt == ARM_LAST) begin
          // The counter never acknowledged: give up and skip the delay.
          delayEnNext    = 1'b0;
          armTimeoutNext = 1'b1;
          pcNext         = pcInc;
          stateNext      = RUN;
        end else begin
          armCntNext = armCnt + CNT_W'(1);
        end
      end

      DLY_WAIT: begin
        if (pcEnS) begin
          pcNext    = pcInc;
          stateNext = RUN;
        end
      end

      HALTED: begin
        stateNext = HALTED;
      end

      default: begin
        stateNext = RUN;
      end
    endcase

    busyNext = (stateNext != RUN);
  end

endmodule
